eth_pcs_tx_ctrl: RTL and testbench
==================================

# eth_pcs_tx_ctrl

Transmit-side sequencer for the 10GBASE-R PCS. It drives the clock-enable and transfer-count inputs of the 64b/66b encoder, and inserts the gearbox pause cycles needed to fit 66-bit blocks onto a 32-bit lane. It also gates MAC XGMII traffic into the encoder: idles are substituted outside the RUN state, and the block enters or leaves RUN only on block boundaries outside a frame. It sits between the MAC XGMII TX interface and the encoder/scrambler/gearbox chain.

## Interface

Parameters:
- GBX_PERIOD, 33: gearbox period in cycles; the last cycle of each period is a pause.
- MIN_IDLE_BLKS, 4: minimum number of idle blocks sent in IDLE before entering RUN.

Ports:
- i_clk  in  1  PCS TX clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_enable  in  1  management transmit enable, level-sensitive.
- i_gbx_ready  in  1  gearbox locked/ready.
- i_xgmii_ctrl  in  N_CHANNELS  MAC control flags.
- i_xgmii_data  in  N_CHANNELS×W_BYTE  MAC data.
- o_xgmii_ready  out  1  MAC word accepted this cycle.
- o_enc_ctrl  out  N_CHANNELS  control flags to the encoder.
- o_enc_data  out  N_CHANNELS×W_BYTE  data to the encoder.
- o_clk_en  out  1  encoder/scrambler clock enable.
- o_trans_cnt  out  W_TRANS_PER_BLK  transfer index within the current block.
- o_blk_last  out  1  this is the final transfer of the block (o_clk_en & o_trans_cnt==N_TRANS_PER_BLK-1).
- o_state  out  2  current FSM state, for status.
- o_abort  out  1  one-cycle pulse: a frame was truncated by loss of i_gbx_ready.

## Operation

- Registers:
  - seq_cnt: 0..GBX_PERIOD-1, wraps to 0.
  - trans_cnt: 0..N_TRANS_PER_BLK-1, wraps to 0.
  - idle_cnt: counts idle blocks sent.
  - in_frame: set while a frame is in progress.
  - state.
- Outputs:
  - o_clk_en = (state != OFF) & (seq_cnt != GBX_PERIOD-1).
  - o_trans_cnt = trans_cnt.
- Counters:
  - seq_cnt increments every cycle outside OFF.
  - trans_cnt increments only on o_clk_en.
  - In OFF, both counters are held at 0.
- States:
  - OFF(0): o_enc_* = idle (all ctrl=1, data=SYM_IDLE); o_xgmii_ready=0. Go to IDLE when i_enable & i_gbx_ready.
  - IDLE(1): idles substituted; o_xgmii_ready=0; idle_cnt increments on each o_blk_last.
    - On o_blk_last with idle_cnt+1 ≥ MIN_IDLE_BLKS and i_enable: go to RUN.
    - On o_blk_last with !i_enable: go to OFF.
  - RUN(2): o_enc_* = i_xgmii_*; o_xgmii_ready = o_clk_en. On o_blk_last with !i_enable and !in_frame (after this word's update): go to IDLE, with idle_cnt cleared.
- in_frame tracking, on accepted words only:
  - Set by any lane with ctrl=1 and data=SYM_START.
  - Cleared by any lane with ctrl=1 and data=SYM_TERM or SYM_ERR.
  - If START and TERM both appear in one word, the lane order decides; the later lane wins.
- !i_gbx_ready in any state except OFF:
  - Next state is OFF; counters and idle_cnt are cleared.
  - If in_frame was set, o_abort pulses once and in_frame is cleared.
  - This takes priority over every other transition.
- Pause cycles: the MAC sees o_xgmii_ready=0 and must hold its word.

## Timing

- Reset values: state=OFF, all counters 0, in_frame=0, o_clk_en=0, o_xgmii_ready=0, o_abort=0, o_enc_* = idle.
- Output paths: o_enc_* and o_xgmii_ready are combinational from the registered state and i_xgmii_*. o_clk_en and o_trans_cnt are decodes of registers only.
- Rate: 32 enabled cycles per 33, i.e. 16 blocks (1056 bits) per period.
- Blocks never straddle a pause in the sense of state changes: transitions out of IDLE/RUN happen only on o_blk_last, so the encoder always sees whole blocks from a single source.
- OFF→IDLE: seq_cnt=0 on the first IDLE cycle.

## Configuration

- ETH_PCS_TX_STATS_EN defined: adds
  - o_frame_cnt (32 bits, saturating): counts frames whose TERM was accepted.
  - o_abort_cnt (16 bits, saturating): counts o_abort pulses.
  - Both are reset to 0 only by i_reset_n.
- Undefined: these ports and counters are absent; all other behaviour is identical.

## Structure

- Additions to eth_pcs_params:
  - GBX_PERIOD default constant.
  - tx_ctrl_state_e enum: OFF=0, IDLE=1, RUN=2.
  - SYM_START, SYM_TERM, SYM_IDLE, SYM_ERR, reused from the existing package.
- Sub-module eth_pcs_tx_frame_mon: in_frame tracking plus the optional stats counters.

## Test plan

- Reset, then i_enable=1, i_gbx_ready=1 → IDLE after 1 cycle; o_clk_en low exactly at seq_cnt=32; 4 idle blocks sent; RUN entered on the 4th o_blk_last.
- RUN, 64-byte frame streamed across pauses → every word is accepted exactly once; no data is lost while o_xgmii_ready=0.
- Deassert i_enable mid-frame → state stays RUN until the TERM word's block ends, then IDLE, then OFF after the next block.
- Drop i_gbx_ready mid-frame → OFF next cycle, single o_abort pulse, o_clk_en=0, counters at 0.
- i_enable held at 0 in IDLE → return to OFF on the next o_blk_last; no MAC word accepted.
- With ETH_PCS_TX_STATS_EN: 3 complete frames plus 1 aborted frame → o_frame_cnt=3, o_abort_cnt=1.

Source files
------------

// File: rtl/eth_pcs_tx_ctrl_pkg.sv
// Shared 10GBASE-R PCS constants: XGMII lane geometry, control symbols and the
// transmit sequencer state encoding.
package eth_pcs_params;

    localparam int N_CHANNELS      = 4;
    localparam int W_BYTE          = 8;
    localparam int N_TRANS_PER_BLK = 2;
    localparam int W_TRANS_PER_BLK = 1;
    localparam int GBX_PERIOD_DEF  = 33;

    localparam logic [W_BYTE-1:0] SYM_IDLE  = 8'h07;
    localparam logic [W_BYTE-1:0] SYM_START = 8'hFB;
    localparam logic [W_BYTE-1:0] SYM_TERM  = 8'hFD;
    localparam logic [W_BYTE-1:0] SYM_ERR   = 8'hFE;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_IDLE = 2'd1,
        ST_RUN  = 2'd2
    } tx_ctrl_state_e;

endpackage

// File: rtl/eth_pcs_tx_ctrl_frame_mon.sv
// Tracks whether a MAC frame is open across accepted XGMII words, flags truncation
// on gearbox loss, and (with ETH_PCS_TX_STATS_EN) keeps saturating frame/abort counts.
module eth_pcs_tx_frame_mon
    import eth_pcs_params::*;
(
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic                         i_accept,
    input  logic                         i_flush,
    input  logic [N_CHANNELS-1:0]        i_ctrl,
    input  logic [N_CHANNELS*W_BYTE-1:0] i_data,
    output logic                         o_in_frame_nxt,
    output logic                         o_abort
`ifdef ETH_PCS_TX_STATS_EN
    ,
    output logic [31:0]                  o_frame_cnt,
    output logic [15:0]                  o_abort_cnt
`endif
);

    logic r_in_frame;
    logic r_abort;
    logic w_walk;
`ifdef ETH_PCS_TX_STATS_EN
    logic        w_term_hit;
    logic [31:0] r_frame_cnt;
    logic [15:0] r_abort_cnt;
`endif

    // Walk lanes in transmit order so the later of START/TERM in one word wins.
    always_comb begin
        w_walk = r_in_frame;
`ifdef ETH_PCS_TX_STATS_EN
        w_term_hit = 1'b0;
`endif
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (i_ctrl[i]) begin
                if (i_data[i*W_BYTE +: W_BYTE] == SYM_START) begin
                    w_walk = 1'b1;
                end else if (i_data[i*W_BYTE +: W_BYTE] == SYM_TERM ||
                             i_data[i*W_BYTE +: W_BYTE] == SYM_ERR) begin
`ifdef ETH_PCS_TX_STATS_EN
                    if (w_walk && i_data[i*W_BYTE +: W_BYTE] == SYM_TERM) w_term_hit = 1'b1;
`endif
                    w_walk = 1'b0;
                end
            end
        end
    end

    assign o_in_frame_nxt = i_accept ? w_walk : r_in_frame;
    assign o_abort        = r_abort;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_in_frame <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            r_abort    <= i_flush & r_in_frame;
            r_in_frame <= i_flush ? 1'b0 : o_in_frame_nxt;
        end
    end

`ifdef ETH_PCS_TX_STATS_EN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_frame_cnt <= '0;
            r_abort_cnt <= '0;
        end else begin
            if (i_accept && w_term_hit && !i_flush && r_frame_cnt != '1)
                r_frame_cnt <= r_frame_cnt + 32'd1;
            if (i_flush && r_in_frame && r_abort_cnt != '1)
                r_abort_cnt <= r_abort_cnt + 16'd1;
        end
    end

    assign o_frame_cnt = r_frame_cnt;
    assign o_abort_cnt = r_abort_cnt;
`endif

endmodule

// File: rtl/eth_pcs_tx_ctrl.sv
// 10GBASE-R PCS transmit sequencer: gearbox pause insertion, encoder enables and
// XGMII gating. Define ETH_PCS_TX_STATS_EN to add frame/abort statistics ports.
module eth_pcs_tx_ctrl
    import eth_pcs_params::*;
#(
    parameter int GBX_PERIOD    = GBX_PERIOD_DEF,
    parameter int MIN_IDLE_BLKS = 4
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic                         i_enable,
    input  logic                         i_gbx_ready,
    input  logic [N_CHANNELS-1:0]        i_xgmii_ctrl,
    input  logic [N_CHANNELS*W_BYTE-1:0] i_xgmii_data,
    output logic                         o_xgmii_ready,
    output logic [N_CHANNELS-1:0]        o_enc_ctrl,
    output logic [N_CHANNELS*W_BYTE-1:0] o_enc_data,
    output logic                         o_clk_en,
    output logic [W_TRANS_PER_BLK-1:0]   o_trans_cnt,
    output logic                         o_blk_last,
    output logic [1:0]                   o_state,
    output logic                         o_abort
`ifdef ETH_PCS_TX_STATS_EN
    ,
    output logic [31:0]                  o_frame_cnt,
    output logic [15:0]                  o_abort_cnt
`endif
);

    localparam int W_SEQ  = $clog2(GBX_PERIOD);
    localparam int W_IDLE = $clog2(MIN_IDLE_BLKS + 2);
    localparam logic [W_SEQ-1:0]           SEQ_LAST   = W_SEQ'(GBX_PERIOD - 1);
    localparam logic [W_TRANS_PER_BLK-1:0] TRANS_LAST = W_TRANS_PER_BLK'(N_TRANS_PER_BLK - 1);
    localparam logic [W_IDLE-1:0]          IDLE_LAST  = W_IDLE'(MIN_IDLE_BLKS - 1);

    tx_ctrl_state_e               r_state;
    logic [W_SEQ-1:0]             r_seq_cnt;
    logic [W_TRANS_PER_BLK-1:0]   r_trans_cnt;
    logic [W_IDLE-1:0]            r_idle_cnt;

    logic w_active;
    logic w_clk_en;
    logic w_blk_last;
    logic w_run;
    logic w_flush;
    logic w_in_frame_nxt;

    assign w_active   = (r_state != ST_OFF);
    assign w_clk_en   = w_active && (r_seq_cnt != SEQ_LAST);
    assign w_blk_last = w_clk_en && (r_trans_cnt == TRANS_LAST);
    assign w_run      = (r_state == ST_RUN);
    assign w_flush    = w_active && !i_gbx_ready;

    assign o_clk_en      = w_clk_en;
    assign o_trans_cnt   = r_trans_cnt;
    assign o_blk_last    = w_blk_last;
    assign o_state       = r_state;
    assign o_xgmii_ready = w_run && w_clk_en;
    assign o_enc_ctrl    = w_run ? i_xgmii_ctrl : {N_CHANNELS{1'b1}};
    assign o_enc_data    = w_run ? i_xgmii_data : {N_CHANNELS{SYM_IDLE}};

    eth_pcs_tx_frame_mon u_frame_mon (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_accept       (o_xgmii_ready),
        .i_flush        (w_flush),
        .i_ctrl         (i_xgmii_ctrl),
        .i_data         (i_xgmii_data),
        .o_in_frame_nxt (w_in_frame_nxt),
        .o_abort        (o_abort)
`ifdef ETH_PCS_TX_STATS_EN
        ,
        .o_frame_cnt    (o_frame_cnt),
        .o_abort_cnt    (o_abort_cnt)
`endif
    );

    // State changes out of IDLE/RUN wait for a block boundary; gearbox loss overrides all.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= ST_OFF;
            r_seq_cnt   <= '0;
            r_trans_cnt <= '0;
            r_idle_cnt  <= '0;
        end else if (w_flush) begin
            r_state     <= ST_OFF;
            r_seq_cnt   <= '0;
            r_trans_cnt <= '0;
            r_idle_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_RUN: begin
                    r_seq_cnt <= (r_seq_cnt == SEQ_LAST) ? '0 : r_seq_cnt + W_SEQ'(1);
                    if (w_clk_en)
                        r_trans_cnt <= (r_trans_cnt == TRANS_LAST) ? '0
                                       : r_trans_cnt + W_TRANS_PER_BLK'(1);
                    if (w_blk_last) begin
                        if (r_state == ST_IDLE) begin
                            if (!i_enable) begin
                                r_state    <= ST_OFF;
                                r_seq_cnt  <= '0;
                                r_idle_cnt <= '0;
                            end else if (r_idle_cnt >= IDLE_LAST) begin
                                r_state    <= ST_RUN;
                                r_idle_cnt <= '0;
                            end else begin
                                r_idle_cnt <= r_idle_cnt + W_IDLE'(1);
                            end
                        end else if (!i_enable && !w_in_frame_nxt) begin
                            r_state    <= ST_IDLE;
                            r_idle_cnt <= '0;
                        end
                    end
                end
                default: begin
                    r_seq_cnt   <= '0;
                    r_trans_cnt <= '0;
                    r_idle_cnt  <= '0;
                    r_state     <= (i_enable && i_gbx_ready) ? ST_IDLE : ST_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_pcs_tx_ctrl.sv
// Self-checking bench for eth_pcs_tx_ctrl: directed table, frame/abort sequences,
// and a randomized run against a cycle-count based reference model.
`timescale 1ns/1ps
module tb_eth_pcs_tx_ctrl;
    import eth_pcs_params::*;

    localparam int GBX      = 33;
    localparam int MIN_IDLE = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        gbx   = 1'b0;
    logic [3:0]  xc    = '0;
    logic [31:0] xd    = '0;

    logic        o_xgmii_ready;
    logic [3:0]  o_enc_ctrl;
    logic [31:0] o_enc_data;
    logic        o_clk_en;
    logic [0:0]  o_trans_cnt;
    logic        o_blk_last;
    logic [1:0]  o_state;
    logic        o_abort;
`ifdef ETH_PCS_TX_STATS_EN
    logic [31:0] frame_cnt;
    logic [15:0] abort_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    eth_pcs_tx_ctrl #(.GBX_PERIOD(GBX), .MIN_IDLE_BLKS(MIN_IDLE)) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_enable      (en),
        .i_gbx_ready   (gbx),
        .i_xgmii_ctrl  (xc),
        .i_xgmii_data  (xd),
        .o_xgmii_ready (o_xgmii_ready),
        .o_enc_ctrl    (o_enc_ctrl),
        .o_enc_data    (o_enc_data),
        .o_clk_en      (o_clk_en),
        .o_trans_cnt   (o_trans_cnt),
        .o_blk_last    (o_blk_last),
        .o_state       (o_state),
        .o_abort       (o_abort)
`ifdef ETH_PCS_TX_STATS_EN
        ,
        .o_frame_cnt   (frame_cnt),
        .o_abort_cnt   (abort_cnt)
`endif
    );

    typedef struct {
        logic       en;
        logic       gbx;
        int         adv;
        logic [1:0] st;
        logic       ce;
        logic       tc;
        logic       bl;
        logic       rdy;
        logic       ab;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; gbx = 1'b0; xc = '0; xd = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic bring_up(output bit ok);
        do_reset();
        en = 1'b1; gbx = 1'b1; xc = 4'hF; xd = {4{SYM_IDLE}};
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            @(negedge clk);
            if (o_state == 2'd2) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
    endtask

    task automatic send_word(input logic [3:0] c, input logic [31:0] d, output bit ok);
        ok = 1'b0; xc = c; xd = d;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (o_xgmii_ready) ok = 1'b1;
            tick();
            if (ok) break;
        end
        xc = 4'hF; xd = {4{SYM_IDLE}};
    endtask

    task automatic rand_word(output logic [3:0] c, output logic [31:0] d);
        int p;
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            p = $urandom_range(0, 15);
            case (p)
                0:       b = SYM_START;
                1:       b = SYM_TERM;
                2:       b = SYM_ERR;
                3:       b = SYM_IDLE;
                default: b = 8'($urandom);
            endcase
            c[i] = (p < 4);
            d[i*8 +: 8] = b;
        end
    endtask

    // Frame state after a word: the highest lane holding START or TERM/ERR decides.
    function automatic bit frame_after(input bit cur, input logic [3:0] c, input logic [31:0] d);
        int ls = -1;
        int lt = -1;
        for (int i = 0; i < 4; i++) begin
            if (c[i]) begin
                if (d[i*8 +: 8] == SYM_START) ls = i;
                if (d[i*8 +: 8] == SYM_TERM || d[i*8 +: 8] == SYM_ERR) lt = i;
            end
        end
        if (ls > lt) return 1'b1;
        if (lt > ls) return 1'b0;
        return cur;
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok, ok2, run_ok, term_bl, seen, acc_idle;
        int idx;
        logic [1:0] exit_st, off_st;
        logic [3:0]  fw_c[18];
        logic [31:0] fw_d[18];
        logic [3:0]  rx_c[$];
        logic [31:0] rx_d[$];
        logic [3:0]  ec;
        logic [31:0] ed;
        int m_st, m_t, m_e, m_idle, nxt;
        bit m_inf, m_ab, e_ce, e_tc, e_bl, e_rdy, last_rdy;

        // ---------------- table-driven bring-up / shutdown ----------------
        tbl[0]  = '{1'b0, 1'b0, 0,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1,  2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1,  2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 6,  2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1,  2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 24, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1,  2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1,  2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1,  2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1,  2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1,  2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 1,  2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        do_reset();
        xc = 4'h0; xd = 32'hA5A5_5A5A;
        for (int r = 0; r < 14; r++) begin
            en = tbl[r].en; gbx = tbl[r].gbx;
            repeat (tbl[r].adv) tick();
            @(negedge clk);
            ec = (tbl[r].st == 2'd2) ? xc : 4'hF;
            ed = (tbl[r].st == 2'd2) ? xd : {4{SYM_IDLE}};
            check($sformatf("tbl%0d", r),
                  {o_state, o_clk_en, o_trans_cnt, o_blk_last, o_xgmii_ready, o_abort, o_enc_ctrl, o_enc_data},
                  {tbl[r].st, tbl[r].ce, tbl[r].tc, tbl[r].bl, tbl[r].rdy, tbl[r].ab, ec, ed});
        end
        tick();

        // ---------------- frame across a pause, enable dropped mid-frame ----------------
        bring_up(ok);
        check("A_bringup", ok, 1);
        repeat (10) tick();
        fw_c[0] = 4'h1; fw_d[0] = {8'hD5, 8'h55, 8'h55, SYM_START};
        for (int i = 1; i < 17; i++) begin
            fw_c[i] = 4'h0; fw_d[i] = $urandom;
        end
        fw_c[17] = 4'hF; fw_d[17] = {SYM_IDLE, SYM_IDLE, SYM_IDLE, SYM_TERM};
        idx = 0; run_ok = 1'b1; term_bl = 1'b0;
        for (int k = 0; k < 200 && idx < 18; k++) begin
            xc = fw_c[idx]; xd = fw_d[idx];
            if (idx >= 5) en = 1'b0;
            @(negedge clk);
            if (o_state != 2'd2) run_ok = 1'b0;
            if (o_xgmii_ready) begin
                rx_c.push_back(o_enc_ctrl);
                rx_d.push_back(o_enc_data);
                if (idx == 17) term_bl = o_blk_last;
                idx++;
            end
            tick();
        end
        xc = 4'hF; xd = {4{SYM_IDLE}};
        check("A_words_accepted", idx, 18);
        check("A_run_held", run_ok, 1);
        check("A_rx_count", rx_c.size(), 18);
        for (int i = 0; i < 18 && i < rx_c.size(); i++)
            check($sformatf("A_word%0d", i), {rx_c[i], rx_d[i]}, {fw_c[i], fw_d[i]});
        seen = term_bl; exit_st = 2'd3; run_ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (seen) begin
                exit_st = o_state;
                break;
            end
            if (o_state != 2'd2) run_ok = 1'b0;
            if (o_blk_last) seen = 1'b1;
            tick();
        end
        tick();
        check("A_idle_after_term_blk", exit_st, 1);
        check("A_no_early_exit", run_ok, 1);
        seen = 1'b0; off_st = 2'd3; acc_idle = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (seen) begin
                off_st = o_state;
                break;
            end
            if (o_xgmii_ready) acc_idle = 1'b1;
            if (o_blk_last) seen = 1'b1;
            tick();
        end
        tick();
        check("A_off_after_idle_blk", off_st, 0);
        check("A_no_accept_in_idle", acc_idle, 0);

        // ---------------- gearbox loss mid-frame ----------------
        bring_up(ok);
        check("B_bringup", ok, 1);
        send_word(4'h1, {8'hD5, 8'h55, 8'h55, SYM_START}, ok);
        send_word(4'h0, 32'hDEAD_BEEF, ok2);
        check("B_words_accepted", {ok, ok2}, 2'b11);
        gbx = 1'b0;
        tick();
        @(negedge clk);
        check("B_off_abort", {o_state, o_abort, o_clk_en, o_trans_cnt, o_xgmii_ready},
              {2'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        tick();
        @(negedge clk);
        check("B_abort_single", o_abort, 0);
        tick();

`ifdef ETH_PCS_TX_STATS_EN
        // ---------------- statistics: 3 frames + 1 aborted ----------------
        bring_up(ok);
        check("C_bringup", ok, 1);
        for (int f = 0; f < 3; f++) begin
            send_word(4'h1, {8'hD5, 8'h55, 8'h55, SYM_START}, ok);
            send_word(4'h0, $urandom, ok);
            send_word(4'hF, {SYM_IDLE, SYM_IDLE, SYM_IDLE, SYM_TERM}, ok);
        end
        send_word(4'h1, {8'hD5, 8'h55, 8'h55, SYM_START}, ok);
        gbx = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("C_frame_cnt", frame_cnt, 3);
        check("C_abort_cnt", abort_cnt, 1);
        tick();
`endif

        // ---------------- randomized run against reference model ----------------
        do_reset();
        m_st = 0; m_t = 0; m_e = 0; m_idle = 0; m_inf = 1'b0; m_ab = 1'b0;
        en = 1'b1; gbx = 1'b1; last_rdy = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 149) == 0) en = ~en;
            gbx = ($urandom_range(0, 299) != 0);
            if (last_rdy) rand_word(xc, xd);
            @(negedge clk);
            e_ce  = (m_st != 0) && ((m_t % GBX) != GBX - 1);
            e_tc  = m_e[0];
            e_bl  = e_ce && e_tc;
            e_rdy = (m_st == 2) && e_ce;
            ec = (m_st == 2) ? xc : 4'hF;
            ed = (m_st == 2) ? xd : {4{SYM_IDLE}};
            check($sformatf("rand_c%0d", cyc),
                  {o_state, o_clk_en, o_trans_cnt, o_blk_last, o_xgmii_ready, o_abort, o_enc_ctrl, o_enc_data},
                  {2'(m_st), e_ce, e_tc, e_bl, e_rdy, m_ab, ec, ed});
            if (m_st != 0 && !gbx) begin
                m_ab = m_inf; m_inf = 1'b0;
                m_st = 0; m_t = 0; m_e = 0; m_idle = 0;
            end else begin
                m_ab = 1'b0;
                if (e_rdy) m_inf = frame_after(m_inf, xc, xd);
                if (m_st == 0) begin
                    if (en && gbx) m_st = 1;
                    m_t = 0; m_e = 0; m_idle = 0;
                end else begin
                    nxt = m_st;
                    if (e_bl) begin
                        if (m_st == 1) begin
                            if (!en) nxt = 0;
                            else if (m_idle + 1 >= MIN_IDLE) begin
                                nxt = 2; m_idle = 0;
                            end else m_idle++;
                        end else if (!en && !m_inf) begin
                            nxt = 1; m_idle = 0;
                        end
                    end
                    if (nxt == 0) begin
                        m_t = 0; m_e = 0; m_idle = 0;
                    end else begin
                        m_t++;
                        if (e_ce) m_e++;
                    end
                    m_st = nxt;
                end
            end
            last_rdy = e_rdy;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
